// File: rtl/uart_tx_mmio_responder_if.sv
// CPU data-bus slave port for the UART transmitter: read/write strobes, byte lanes, address and data.
// Purely combinational signal bundle; no flow control beyond the strobes themselves.
interface uart_tx_mmio_responder_if;
    logic        wReadEnable;
    logic        wWriteEnable;
    logic [3:0]  wByteEnable;
    logic [63:0] wAddress;
    logic [63:0] wWriteData;
    logic [63:0] wReadData;

    modport master (
        output wReadEnable,
        output wWriteEnable,
        output wByteEnable,
        output wAddress,
        output wWriteData,
        input  wReadData
    );

    modport slave (
        input  wReadEnable,
        input  wWriteEnable,
        input  wByteEnable,
        input  wAddress,
        input  wWriteData,
        output wReadData
    );
endinterface

// File: rtl/uart_tx_mmio_responder.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, STATUS and BAUDDIV registers.
// Latency: reads combinational; a TXDATA write into an idle, empty block drives the start bit one edge later.
// Backpressure: none on the bus; a push into a full FIFO is dropped and flagged in the sticky overflow bit.
module uart_tx_mmio_responder #(
    parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_FF20_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic                            iCLK,
    input  logic                            iRST,
    uart_tx_mmio_responder_if.slave         bus,
    output logic                            oTX,
    output logic                            oBusy,
    output logic                            oIRQ
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_BAUDDIV = 2'd2;

    logic [1:0]    state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          irqen;
    logic [15:0]   div;
    logic [15:0]   div_m1;
    logic [15:0]   baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    logic          hit;
    logic [1:0]    offs;
    logic          wr_hit;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          empty;
    logic          full;
    logic          boundary;
    logic [7:0]    count_ext;
    logic [3:0]    count4;
    logic [63:0]   status_word;

    assign hit      = (bus.wAddress[63:5] == BASE_ADDR[63:5]);
    assign offs     = bus.wAddress[4:3];
    assign wr_hit   = bus.wWriteEnable && hit;
    assign push_req = wr_hit && (offs == OFF_TXDATA) && bus.wByteEnable[0];

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign pop      = (state == S_IDLE) && !empty;
    // The FSM pop frees a slot in the same cycle, so a push at full still fits.
    assign push_ok  = push_req && (!full || pop);

    // div of zero behaves as one; >= lets a shrunken divider end the bit on the next edge.
    assign div_m1   = (div == 16'd0) ? 16'd0 : (div - 16'd1);
    assign boundary = (baud_cnt >= div_m1);

    assign oBusy    = (state != S_IDLE) || !empty;
    assign oIRQ     = empty && (state == S_IDLE) && irqen;

    always_comb begin
        oTX = 1'b1;
        case (state)
            S_START: oTX = 1'b0;
            S_DATA:  oTX = shift[0];
            default: oTX = 1'b1;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.wWriteData[7:0];
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            overflow <= 1'b0;
            irqen    <= 1'b0;
            div      <= DEFAULT_DIV;
        end else begin
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
            if (wr_hit && (offs == OFF_STATUS)) begin
                if (bus.wWriteData[3]) begin
                    overflow <= 1'b0;
                end
                irqen <= bus.wWriteData[4];
            end
            if (wr_hit && (offs == OFF_BAUDDIV)) begin
                div <= bus.wWriteData[15:0];
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shift    <= mem[rd_ptr];
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (boundary) begin
                        baud_cnt <= '0;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (boundary) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    if (boundary) begin
                        baud_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    assign count_ext   = {{(8-CW){1'b0}}, count};
    assign count4      = count_ext[3:0];
    assign status_word = {52'b0, count4, 3'b0, irqen, overflow, empty, full, oBusy};

    // Unselected reads return zero so several slaves can be OR-combined.
    always_comb begin
        bus.wReadData = '0;
        if (bus.wReadEnable && hit) begin
            case (offs)
                OFF_STATUS:  bus.wReadData = status_word;
                OFF_BAUDDIV: bus.wReadData = {48'b0, div};
                default:     bus.wReadData = '0;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, bus.wAddress[2:0], bus.wWriteData[63:16],
                           bus.wByteEnable[3:1], count_ext[7:4]};

endmodule

// File: tb/tb_uart_tx_mmio_responder.sv
// Scoreboard bench for uart_tx_mmio_responder: bytes queued at write time, compared when decoded off oTX.
module tb_uart_tx_mmio_responder;
    localparam logic [63:0] BASE = 64'h0000_0000_FF20_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx, busy, irq;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    logic [7:0] sb_q[$];

    uart_tx_mmio_responder_if bus_if();

    uart_tx_mmio_responder #(
        .BASE_ADDR(BASE), .FIFO_DEPTH(8), .DEFAULT_DIV(16'd434)
    ) dut (
        .iCLK(clk), .iRST(rst_n), .bus(bus_if),
        .oTX(tx), .oBusy(busy), .oIRQ(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic bus_write(input logic [63:0] a, input logic [63:0] d, input logic [3:0] be);
        @(negedge clk);
        bus_if.wWriteEnable = 1'b1;
        bus_if.wAddress     = a;
        bus_if.wWriteData   = d;
        bus_if.wByteEnable  = be;
        @(negedge clk);
        bus_if.wWriteEnable = 1'b0;
        bus_if.wByteEnable  = 4'b0000;
    endtask

    task automatic txdata_write(input logic [7:0] b);
        bus_write(BASE, {56'b0, b}, 4'b0001);
        sb_q.push_back(b);
    endtask

    task automatic bus_read(input logic [63:0] a, output logic [63:0] d);
        bus_if.wReadEnable = 1'b1;
        bus_if.wAddress    = a;
        #1;
        d = bus_if.wReadData;
        bus_if.wReadEnable = 1'b0;
    endtask

    task automatic capture_frame(input int div, output logic [7:0] d, output bit ok);
        int waited = 0;
        ok = 1'b1;
        d  = 8'h00;
        @(negedge clk);
        while (tx !== 1'b0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (tx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        repeat (div / 2) @(negedge clk);
        if (tx !== 1'b0) ok = 1'b0;
        for (int j = 0; j < 8; j++) begin
            repeat (div) @(negedge clk);
            d[j] = tx;
        end
        repeat (div) @(negedge clk);
        if (tx !== 1'b1) ok = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] rd;
        bus_if.wReadEnable = 1'b0; bus_if.wWriteEnable = 1'b0;
        bus_if.wByteEnable = 4'b0; bus_if.wAddress = '0; bus_if.wWriteData = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bus_write(BASE + 64'h10, 64'd50, 4'hF);
        bus_write(BASE, 64'h55, 4'b0001);
        repeat (30) @(negedge clk);
        checks++; if (tx !== 1'b0) $display("FAIL pre_reset_start_bit tx=%b want 0", tx); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) $display("FAIL reset_tx_async tx=%b want 1", tx); else passed++;
        checks++; if (busy !== 1'b0 || irq !== 1'b0) $display("FAIL reset_busy_irq busy=%b irq=%b want 0 0", busy, irq); else passed++;
        bus_read(BASE + 64'h08, rd);
        checks++; if (rd !== 64'h4) $display("FAIL reset_status_during got=%h want 4", rd); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(BASE + 64'h08, rd);
        checks++; if (rd !== 64'h4) $display("FAIL status_after_reset got=%h want 4", rd); else passed++;
        bus_read(BASE + 64'h10, rd);
        checks++; if (rd !== 64'd434) $display("FAIL bauddiv_reset got=%0d want 434", rd); else passed++;
        checks++; if (tx !== 1'b1 || irq !== 1'b0) $display("FAIL idle_after_reset tx=%b irq=%b want 1 0", tx, irq); else passed++;
        bus_read(64'h0000_0000_FF30_0008, rd);
        checks++; if (rd !== 64'h0) $display("FAIL unselected_read got=%h want 0", rd); else passed++;
    endtask

    task automatic test_single_frame();
        logic [63:0] rd;
        logic [39:0] got, exp;
        logic [7:0]  b, d;
        logic        busy_last;
        b = 8'hA5;
        bus_write(BASE + 64'h10, 64'd4, 4'hF);
        bus_read(BASE + 64'h10, rd);
        checks++; if (rd !== 64'd4) $display("FAIL bauddiv_write got=%0d want 4", rd); else passed++;
        txdata_write(b);
        checks++; if (tx !== 1'b1) $display("FAIL tx_before_pop tx=%b want 1", tx); else passed++;
        busy_last = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            got[k] = tx;
            if (k == 39) busy_last = busy;
        end
        exp[3:0] = 4'h0;
        for (int j = 0; j < 8; j++) exp[4 + 4*j +: 4] = {4{b[j]}};
        exp[39:36] = 4'hF;
        checks++; if (got !== exp) $display("FAIL frame_waveform got=%h want %h", got, exp); else passed++;
        checks++; if (busy_last !== 1'b1) $display("FAIL busy_in_stop busy=%b want 1", busy_last); else passed++;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL busy_after_stop busy=%b want 0", busy); else passed++;
        for (int j = 0; j < 8; j++) d[j] = got[4 + 4*j + 2];
        checks++;
        if (sb_q.size() == 0) $display("FAIL single_frame_sb got=%h want queued byte", d);
        else begin
            b = sb_q.pop_front();
            if (d !== b) $display("FAIL single_frame_sb got=%h want %h", d, b); else passed++;
        end
    endtask

    task automatic test_decode();
        logic [63:0] rd;
        bus_write(BASE, 64'h77, 4'b0000);
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL be0_no_push busy=%b want 0", busy); else passed++;
        bus_read(BASE + 64'h08, rd);
        checks++; if (rd !== 64'h4) $display("FAIL be0_status got=%h want 4", rd); else passed++;
        bus_write(BASE + 64'h18, '1, 4'hF);
        bus_read(BASE + 64'h08, rd);
        checks++; if (rd !== 64'h4) $display("FAIL reserved_write_status got=%h want 4", rd); else passed++;
        bus_read(BASE + 64'h10, rd);
        checks++; if (rd !== 64'd4) $display("FAIL reserved_write_div got=%0d want 4", rd); else passed++;
        bus_write(BASE + 64'h20, 64'h77, 4'b0001);
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL out_of_window_write busy=%b want 0", busy); else passed++;
        bus_read(BASE, rd);
        checks++; if (rd !== 64'h0) $display("FAIL txdata_read got=%h want 0", rd); else passed++;
        bus_read(BASE + 64'h18, rd);
        checks++; if (rd !== 64'h0) $display("FAIL reserved_read got=%h want 0", rd); else passed++;
        bus_read(BASE + 64'h28, rd);
        checks++; if (rd !== 64'h0) $display("FAIL next_window_read got=%h want 0", rd); else passed++;
        bus_if.wReadEnable = 1'b0;
        bus_if.wAddress = BASE + 64'h08;
        #1;
        checks++; if (bus_if.wReadData !== 64'h0) $display("FAIL no_read_strobe got=%h want 0", bus_if.wReadData); else passed++;
    endtask

    task automatic test_overflow();
        logic [63:0] rd;
        int n_edge;
        int t_edge;
        bus_write(BASE + 64'h10, 64'd100, 4'hF);
        fork
            begin : monitor
                logic [7:0] d, e;
                bit ok;
                for (int f = 0; f < 10; f++) begin
                    capture_frame(100, d, ok);
                    checks++;
                    if (!ok) $display("FAIL fifo_frame_%0d framing/timeout got=%h", f, d);
                    else if (sb_q.size() == 0) $display("FAIL fifo_frame_%0d got=%h want none", f, d);
                    else begin
                        e = sb_q.pop_front();
                        if (d !== e) $display("FAIL fifo_frame_%0d got=%h want %h", f, d, e); else passed++;
                    end
                end
            end
            begin : driver
                @(negedge clk);
                n_edge = cyc + 1;
                for (int i = 0; i < 10; i++) begin
                    bus_if.wWriteEnable = 1'b1;
                    bus_if.wAddress     = BASE;
                    bus_if.wByteEnable  = 4'b0001;
                    bus_if.wWriteData   = 64'(8'h10 + i);
                    if (i < 9) sb_q.push_back(8'(8'h10 + i));
                    @(negedge clk);
                end
                bus_if.wWriteEnable = 1'b0;
                bus_if.wByteEnable  = 4'b0000;
                bus_read(BASE + 64'h08, rd);
                checks++; if (rd !== 64'h80B) $display("FAIL overflow_status got=%h want 80b", rd); else passed++;
                bus_write(BASE + 64'h08, 64'h8, 4'hF);
                bus_read(BASE + 64'h08, rd);
                checks++; if (rd !== 64'h803) $display("FAIL overflow_clear got=%h want 803", rd); else passed++;
                t_edge = n_edge + 1002;
                while (cyc < t_edge - 1) @(negedge clk);
                bus_if.wWriteEnable = 1'b1;
                bus_if.wAddress     = BASE;
                bus_if.wByteEnable  = 4'b0001;
                bus_if.wWriteData   = 64'hEE;
                sb_q.push_back(8'hEE);
                @(negedge clk);
                bus_if.wWriteEnable = 1'b0;
                bus_if.wByteEnable  = 4'b0000;
                bus_read(BASE + 64'h08, rd);
                checks++; if (rd !== 64'h803) $display("FAIL push_pop_at_full got=%h want 803", rd); else passed++;
            end
        join
        for (int w = 0; w < 2000 && busy === 1'b1; w++) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL fifo_drain busy=%b want 0", busy); else passed++;
    endtask

    task automatic test_irq_div();
        logic [63:0] rd;
        logic [9:0]  got, exp;
        logic [7:0]  b, e;
        int n;
        b = 8'h3C;
        bus_write(BASE + 64'h08, 64'h10, 4'hF);
        bus_read(BASE + 64'h08, rd);
        checks++; if (rd !== 64'h14) $display("FAIL irqen_status got=%h want 14", rd); else passed++;
        checks++; if (irq !== 1'b1) $display("FAIL irq_idle irq=%b want 1", irq); else passed++;
        bus_write(BASE + 64'h10, 64'd0, 4'hF);
        bus_read(BASE + 64'h10, rd);
        checks++; if (rd !== 64'd0) $display("FAIL div0_read got=%0d want 0", rd); else passed++;
        txdata_write(b);
        checks++; if (irq !== 1'b0) $display("FAIL irq_pending irq=%b want 0", irq); else passed++;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            got[k] = tx;
        end
        exp = {1'b1, b, 1'b0};
        checks++; if (got !== exp) $display("FAIL div0_frame got=%h want %h", got, exp); else passed++;
        checks++;
        if (sb_q.size() == 0) $display("FAIL div0_sb got=%h want queued byte", got[8:1]);
        else begin
            e = sb_q.pop_front();
            if (got[8:1] !== e) $display("FAIL div0_sb got=%h want %h", got[8:1], e); else passed++;
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || irq !== 1'b1) $display("FAIL irq_after_frame busy=%b irq=%b want 0 1", busy, irq); else passed++;
        bus_write(BASE + 64'h10, 64'd8, 4'hF);
        bus_write(BASE, 64'h01, 4'b0001);
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b0 || irq !== 1'b0) $display("FAIL mid_start tx=%b irq=%b want 0 0", tx, irq); else passed++;
        bus_write(BASE + 64'h10, 64'd2, 4'hF);
        n = 0;
        while (tx !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        checks++; if (tx !== 1'b1 || n > 2) $display("FAIL div_shrink_boundary cycles=%0d want <=2", n); else passed++;
        for (int w = 0; w < 200 && busy === 1'b1; w++) @(negedge clk);
        bus_read(BASE + 64'h08, rd);
        checks++; if (rd !== 64'h14 || irq !== 1'b1) $display("FAIL div_shrink_done status=%h irq=%b want 14 1", rd, irq); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_decode();
        test_overflow();
        test_irq_div();
        checks++; if (sb_q.size() != 0) $display("FAIL scoreboard_leftover got=%0d want 0", sb_q.size()); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_mmio_responder.md
Name: uart_tx_mmio_responder

Overview:
- Memory-mapped UART transmitter that responds on the CPU data bus as a bus slave, the responder end of the CPU's data-bus initiator.
- Sits beside the data memory interface and decodes its own 32-byte address window.
- Accepts bytes through register writes into a TX FIFO and serialises them as 8N1 on a single output pin.
- Status and baud-divider registers are readable by the CPU.

Parameters:
- BASE_ADDR, 64'h0000_0000_FF20_0000, base of the 32-byte register window (bits [4:0] must be zero).
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of two, 2..16.
- DEFAULT_DIV, 16'd434, reset value of BAUDDIV (50 MHz / 115200).

Ports:
- iCLK  input  1  CPU clock; all state changes on rising edge.
- iRST  input  1  asynchronous, active-low reset.
- wReadEnable  input  1  bus read strobe.
- wWriteEnable  input  1  bus write strobe.
- wByteEnable  input  4  byte lanes; bit0 gates TXDATA writes.
- wAddress  input  64  byte address.
- wWriteData  input  64  write data.
- wReadData  output  64  read data; 0 when not selected.
- oTX  output  1  serial line, idle high.
- oBusy  output  1  high while a frame is in flight or the FIFO is non-empty.
- oIRQ  output  1  level interrupt: FIFO empty AND FSM idle AND IRQEN set.

Behaviour:
- Decode:
  - hit = (wAddress[63:5] == BASE_ADDR[63:5]).
  - Offset wAddress[4:3]: 0 = TXDATA, 1 = STATUS, 2 = BAUDDIV, 3 = reserved.
- Reads are combinational. When wReadEnable && hit:
  - TXDATA reads 0.
  - STATUS = {52'b0, count[3:0], irqen, overflow, empty, full, busy} at bits [11:8], 4, 3, 2, 1, 0.
  - BAUDDIV = {48'b0, div}.
  - Reserved reads 0.
  - Otherwise wReadData = 0, which allows OR-muxing with other slaves.
- Writes take effect at the rising edge when wWriteEnable && hit:
  - TXDATA with wByteEnable[0]=1 pushes wWriteData[7:0]. With wByteEnable[0]=0 it is ignored.
  - STATUS: bit3=1 clears overflow; bit4 loads irqen.
  - BAUDDIV loads div = wWriteData[15:0]. div=0 is treated as 1.
  - Reserved writes are ignored.
- FIFO:
  - Circular buffer with wr_ptr, rd_ptr and count (0..FIFO_DEPTH). Pointers wrap modulo FIFO_DEPTH.
  - A push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - A rejected push drops the byte and sets the sticky overflow bit.
  - Simultaneous push and pop leaves count unchanged.
  - full = (count==FIFO_DEPTH); empty = (count==0).
- FSM states IDLE, START, DATA, STOP:
  - IDLE: oTX=1. If !empty, pop into shift register, reset baud counter and bit index, go to START.
  - START: oTX=0 for div cycles, then go to DATA.
  - DATA: oTX=shift[0] for div cycles per bit, LSB first. Shift right after each bit; after bit index 7 go to STOP.
  - STOP: oTX=1 for div cycles, then go to IDLE.
  - Back-to-back frames are separated by exactly one IDLE cycle.
- Baud counter:
  - Counts 0..div-1; a bit boundary occurs when counter == div-1.
  - A div write mid-frame takes effect at the next boundary comparison. The counter is not reset, but is clamped: if counter >= new div-1, the boundary fires on the next cycle.
- Latency: a TXDATA write at edge N into an empty FIFO with the FSM idle → pop at edge N+1 → oTX low from edge N+1. The frame is 10*div cycles long.
- oBusy = (state != IDLE) || !empty, registered-equivalent (derived from registered state).
- Reset (iRST=0, asynchronous):
  - state=IDLE, oTX=1, FIFO pointers and count = 0, overflow=0, irqen=0, div=DEFAULT_DIV.
  - Outputs during reset: oBusy=0, oIRQ=0, wReadData per decode (STATUS reads 0x004).
  - Reset mid-frame aborts immediately; oTX goes high asynchronously.

Test Plan:
- Reset/readback: assert iRST=0 mid-operation, release → STATUS reads 64'h004, BAUDDIV reads 434, oTX=1, oIRQ=0; an unselected address reads 0.
- Single frame: write div=4, write TXDATA=0xA5 at edge N → oTX low at N+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, stop high for 4 cycles, 40 cycles total; oBusy falls after STOP.
- FIFO full/overflow: div=100, write 10 bytes quickly with FIFO_DEPTH=8 → the first byte pops immediately, so 9 are accepted (count=8, full=1), the 10th is dropped with overflow=1; writing STATUS bit3=1 clears overflow; exactly 9 frames go out in order.
- Push at full with simultaneous pop: FIFO full, write lands in the FSM's IDLE pop cycle → accepted, count stays 8, overflow stays 0.
- Byte enable/decode: TXDATA write with wByteEnable=4'b0000 → no push; write to BASE+0x18 → no effect; write to BASE+0x20 → not decoded.
- IRQ and div edge cases: irqen=1 → oIRQ=1 when idle and empty, 0 during a frame; div=0 → each bit lasts 1 cycle (10-cycle frame); div changed 8→2 mid-bit → the next boundary fires within at most 2 cycles.
